tile_seq_ctrl: RTL and testbench
================================

Name: tile_seq_ctrl

Overview:
- Sequences the edge-detection core one tile at a time: per-tile core soft reset, 80-beat pixel load (5 lanes x 5b per beat = 20x20 tile), wait for processing, then drain 324 (18x18) edge bits.
- Sits between the pixel source / edge sink and the core.
- Owns the core's per-tile reset, load_end and readable qualification.
- Repeats for a configured number of tiles per run.

Parameters:
- IN_BEATS, 80, input beats per tile.
- OUT_BEATS, 324, output edge bits per tile.
- NUM_TILES, 12, tiles per run (>=1).
- TILE_W, 4, width of tile_idx; must hold NUM_TILES-1.
- PROC_TIMEOUT, 1024, watchdog limit in cycles (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  controller reset.
- start  in  1  begin a run; sampled only in IDLE.
- in_valid  in  1  source presents a pixel beat.
- in_ready  out  1  controller accepts beat; a beat transfers on in_valid & in_ready.
- core_rst  out  1  one-cycle soft reset to core before each tile.
- core_load_en  out  1  = in_valid & in_ready (combinational); core captures beat.
- load_end  out  1  tile fully loaded.
- core_done  in  1  core has first edge bit ready (level).
- readable  out  1  edge bit on core output is valid.
- out_ready  in  1  sink consumes edge bit; transfer on readable & out_ready.
- tile_idx  out  TILE_W  current tile number.
- busy  out  1  high in any state except IDLE.
- run_done  out  1  one-cycle pulse after last tile drained.

Behaviour:
- Clocking and reset: single clock clk; reset is synchronous, active-high.
- Reset state: state=IDLE, all counters 0, every output 0 (tile_idx=0).
- Reset mid-operation: abandon the tile, return to IDLE next edge; no run_done pulse.
- States: IDLE, CRST, LOAD, PROC, DRAIN, NEXT, DONE.
- IDLE:
  - start=1 -> CRST; tile_idx<=0.
  - start while busy is ignored.
- CRST: core_rst=1 for exactly one cycle; in_cnt<=0, out_cnt<=0, load_end<=0; -> LOAD.
- LOAD:
  - in_ready=1; in_cnt increments per accepted beat.
  - Accept with in_cnt==IN_BEATS-1 -> PROC; load_end registered high the following cycle.
  - in_valid low stalls without penalty.
  - core_done is ignored in LOAD.
- PROC:
  - in_ready=0; load_end=1.
  - core_done=1 -> DRAIN next cycle.
  - in_valid ignored.
- DRAIN:
  - readable=1, load_end stays 1.
  - out_cnt increments on out_ready.
  - Accept with out_cnt==OUT_BEATS-1 -> NEXT.
  - out_ready low holds readable and count.
- NEXT:
  - tile_idx==NUM_TILES-1 -> DONE.
  - Otherwise tile_idx+1 -> CRST.
- DONE: run_done=1 for one cycle, load_end<=0; -> IDLE. tile_idx holds last value until next start.
- Per-tile cycle overhead: CRST(1) + NEXT(1) with zero stalls.
- Counter widths:
  - in_cnt: $clog2(IN_BEATS).
  - out_cnt: $clog2(OUT_BEATS).
  - Both compare for equality only; no wrap is ever reached.
- NUM_TILES=1: NEXT goes straight to DONE.

Optional Feature:
- Macro: TILE_SEQ_WATCHDOG_EN.
- When defined:
  - adds output proc_timeout (1b, sticky until reset or start in IDLE).
  - a cycle counter runs in PROC.
  - If core_done is absent for PROC_TIMEOUT cycles: set proc_timeout, skip DRAIN, go to NEXT. The tile yields no output beats.
- When undefined: port and counter absent; PROC waits indefinitely.

Decomposition:
- Shared package tile_seq_pkg holds:
  - the state enum;
  - tile geometry constants: TILE_IN_DIM=20, TILE_OUT_DIM=18, LANES=5, PIX_W=5;
  - derived IN_BEATS and OUT_BEATS defaults.
- One natural sub-module, beat_counter:
  - parameterised modulo counter with clear, enable and terminal-count flag.
  - instantiated for in_cnt, out_cnt and (optionally) the watchdog.

Test Plan:
1. Basic run, NUM_TILES=2, in_valid and out_ready tied 1, core_done 5 cycles after load_end:
   - core_rst pulses twice;
   - 80 core_load_en per tile;
   - 324 readable transfers per tile;
   - run_done pulse once;
   - tile_idx goes 0 then 1.
2. Source stalls: in_valid toggles 1/0 -> still exactly 80 accepts; load_end rises one cycle after the 80th accept, not before.
3. Sink backpressure: out_ready low 10 cycles mid-drain at out_cnt=100 -> readable held high, no count advance, total transfers 324.
4. Reset mid-LOAD at in_cnt=40 -> next cycle IDLE, all outputs 0; a fresh start runs a complete tile from tile_idx=0.
5. Spurious inputs:
   - core_done high during LOAD does not shorten the load;
   - start pulsed during DRAIN is ignored;
   - in_valid during PROC gives no core_load_en.
6. With TILE_SEQ_WATCHDOG_EN and PROC_TIMEOUT=16, core_done never asserted:
   - proc_timeout set after 16 PROC cycles;
   - no readable;
   - moves on to the next tile;
   - run_done still pulses at end.

Source files
------------

// File: rtl/tile_seq_pkg.sv
// Shared types and tile geometry for the tile sequencer.
package tile_seq_pkg;

    localparam int unsigned TILE_IN_DIM  = 20;
    localparam int unsigned TILE_OUT_DIM = 18;
    localparam int unsigned LANES        = 5;
    localparam int unsigned PIX_W        = 5;
    localparam int unsigned BEAT_W       = LANES * PIX_W;

    localparam int unsigned IN_BEATS_DEF  = (TILE_IN_DIM * TILE_IN_DIM) / LANES;
    localparam int unsigned OUT_BEATS_DEF = TILE_OUT_DIM * TILE_OUT_DIM;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRST,
        ST_LOAD,
        ST_PROC,
        ST_DRAIN,
        ST_NEXT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/beat_counter.sv
// Modulo counter with synchronous clear, count enable and terminal-count flag.
module beat_counter #(
    parameter int unsigned MOD   = 80,
    parameter int unsigned CNT_W = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [CNT_W-1:0] cnt;

    assign tc_c = (cnt == CNT_W'(MOD - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tile_seq_ctrl.sv
// Tile sequencer for the edge-detection core: core reset, load, wait, drain, per tile.
// Optional PROC watchdog enabled by defining TILE_SEQ_WATCHDOG_EN.
module tile_seq_ctrl
    import tile_seq_pkg::*;
#(
    parameter int unsigned IN_BEATS  = IN_BEATS_DEF,
    parameter int unsigned OUT_BEATS = OUT_BEATS_DEF,
    parameter int unsigned NUM_TILES = 12,
    parameter int unsigned TILE_W    = 4
`ifdef TILE_SEQ_WATCHDOG_EN
    , parameter int unsigned PROC_TIMEOUT = 1024
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              core_rst,
    output logic              core_load_en,
    output logic              load_end,
    input  logic              core_done,
    output logic              readable,
    input  logic              out_ready,
    output logic [TILE_W-1:0] tile_idx,
    output logic              busy,
    output logic              run_done
`ifdef TILE_SEQ_WATCHDOG_EN
    , output logic            proc_timeout
`endif
);

    state_e state;
    logic   in_tc_c;
    logic   out_tc_c;
    logic   out_xfer_c;

    assign core_load_en = in_valid & in_ready;
    assign out_xfer_c   = readable & out_ready;

    beat_counter #(.MOD(IN_BEATS)) u_in_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state == ST_CRST),
        .en    (core_load_en),
        .tc_c  (in_tc_c)
    );

    beat_counter #(.MOD(OUT_BEATS)) u_out_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state == ST_CRST),
        .en    (out_xfer_c),
        .tc_c  (out_tc_c)
    );

`ifdef TILE_SEQ_WATCHDOG_EN
    logic wd_tc_c;

    // Counts consecutive PROC cycles; cleared whenever the FSM is elsewhere.
    beat_counter #(.MOD(PROC_TIMEOUT)) u_wd_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state != ST_PROC),
        .en    (state == ST_PROC),
        .tc_c  (wd_tc_c)
    );
`endif

    // Outputs are registered from the transition taken, so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            tile_idx <= '0;
            in_ready <= 1'b0;
            core_rst <= 1'b0;
            load_end <= 1'b0;
            readable <= 1'b0;
            busy     <= 1'b0;
            run_done <= 1'b0;
`ifdef TILE_SEQ_WATCHDOG_EN
            proc_timeout <= 1'b0;
`endif
        end else begin
            core_rst <= 1'b0;
            run_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_CRST;
                        tile_idx <= '0;
                        core_rst <= 1'b1;
                        busy     <= 1'b1;
`ifdef TILE_SEQ_WATCHDOG_EN
                        proc_timeout <= 1'b0;
`endif
                    end
                end
                ST_CRST: begin
                    state    <= ST_LOAD;
                    in_ready <= 1'b1;
                end
                ST_LOAD: begin
                    if (core_load_en && in_tc_c) begin
                        state    <= ST_PROC;
                        in_ready <= 1'b0;
                        load_end <= 1'b1;
                    end
                end
                ST_PROC: begin
                    if (core_done) begin
                        state    <= ST_DRAIN;
                        readable <= 1'b1;
                    end
`ifdef TILE_SEQ_WATCHDOG_EN
                    else if (wd_tc_c) begin
                        state        <= ST_NEXT;
                        proc_timeout <= 1'b1;
                    end
`endif
                end
                ST_DRAIN: begin
                    if (out_xfer_c && out_tc_c) begin
                        state    <= ST_NEXT;
                        readable <= 1'b0;
                    end
                end
                ST_NEXT: begin
                    load_end <= 1'b0;
                    if (tile_idx == TILE_W'(NUM_TILES - 1)) begin
                        state    <= ST_DONE;
                        run_done <= 1'b1;
                    end else begin
                        state    <= ST_CRST;
                        tile_idx <= tile_idx + TILE_W'(1);
                        core_rst <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    load_end <= 1'b0;
                    readable <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_seq_ctrl.sv
// Randomized bench for tile_seq_ctrl against a phase/count reference model.
// Watchdog checks are compiled in when TILE_SEQ_WATCHDOG_EN is defined.
module tb_tile_seq_ctrl;

    localparam int NT = 3;
    localparam int IB = 80;
    localparam int OB = 324;
    localparam int TW = 4;
    localparam int PT = 16;
`ifdef TILE_SEQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_CRST  = 1;
    localparam int P_LOAD  = 2;
    localparam int P_PROC  = 3;
    localparam int P_DRAIN = 4;
    localparam int P_NEXT  = 5;
    localparam int P_DONE  = 6;

    logic clk = 1'b0;
    logic reset, start, in_valid, core_done, out_ready;
    logic in_ready, core_rst, core_load_en, load_end, readable, busy, run_done;
    logic [TW-1:0] tile_idx;
`ifdef TILE_SEQ_WATCHDOG_EN
    logic proc_timeout;
`endif

    always #5 clk = ~clk;

    tile_seq_ctrl #(
        .IN_BEATS (IB),
        .OUT_BEATS(OB),
        .NUM_TILES(NT),
        .TILE_W   (TW)
`ifdef TILE_SEQ_WATCHDOG_EN
        , .PROC_TIMEOUT(PT)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .core_rst    (core_rst),
        .core_load_en(core_load_en),
        .load_end    (load_end),
        .core_done   (core_done),
        .readable    (readable),
        .out_ready   (out_ready),
        .tile_idx    (tile_idx),
        .busy        (busy),
        .run_done    (run_done)
`ifdef TILE_SEQ_WATCHDOG_EN
        , .proc_timeout(proc_timeout)
`endif
    );

    int total = 0;
    int bad   = 0;

    // reference model: phase of the tile sequence plus plain counts
    int m_ph, m_in, m_out, m_wd, m_tile;
    bit m_to;

    // stimulus policy
    int pv, pr, done_mode, start_pct, hold_left;
    bit force_start, hold_en;

    // observed event counts for the current run
    int n_load, n_xfer, n_rst, n_done;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_in = 0; m_out = 0; m_wd = 0; m_tile = 0; m_to = 1'b0;
    endtask

    task automatic clear_stats();
        n_load = 0; n_xfer = 0; n_rst = 0; n_done = 0;
    endtask

    // One clock: drive inputs, compare outputs with the model, advance the model.
    task automatic cycle(input bit rst);
        @(negedge clk);
        reset    = rst;
        start    = force_start || ($urandom_range(99) < start_pct);
        in_valid = $urandom_range(99) < pv;
        if (m_ph == P_CRST) hold_left = 10;
        if (hold_en && m_ph == P_DRAIN && m_out == 100 && hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
        end else begin
            out_ready = $urandom_range(99) < pr;
        end
        case (done_mode)
            0:       core_done = $urandom_range(99) < 30;
            1:       core_done = (m_ph == P_PROC) ? (m_wd >= 5) : ($urandom_range(1) == 1);
            default: core_done = 1'b0;
        endcase
        #1;
        chk("in_ready",     in_ready,     m_ph == P_LOAD);
        chk("core_load_en", core_load_en, (m_ph == P_LOAD) && in_valid);
        chk("core_rst",     core_rst,     m_ph == P_CRST);
        chk("load_end",     load_end,     m_ph == P_PROC || m_ph == P_DRAIN || m_ph == P_NEXT);
        chk("readable",     readable,     m_ph == P_DRAIN);
        chk("busy",         busy,         m_ph != P_IDLE);
        chk("run_done",     run_done,     m_ph == P_DONE);
        chk("tile_idx",     tile_idx,     m_tile);
`ifdef TILE_SEQ_WATCHDOG_EN
        chk("proc_timeout", proc_timeout, m_to);
`endif
        if (hold_en && m_ph == P_DRAIN && m_out == 100 && !out_ready) chk("hold_readable", readable, 1);
        n_load += int'(core_load_en);
        n_xfer += int'(readable && out_ready);
        n_rst  += int'(core_rst);
        n_done += int'(run_done);

        if (rst) begin
            model_reset();
        end else begin
            case (m_ph)
                P_IDLE: if (start) begin m_ph = P_CRST; m_tile = 0; m_to = 1'b0; end
                P_CRST: begin m_ph = P_LOAD; m_in = 0; m_out = 0; end
                P_LOAD: if (in_valid) begin
                    m_in++;
                    if (m_in == IB) begin m_ph = P_PROC; m_wd = 0; end
                end
                P_PROC: begin
                    if (core_done) m_ph = P_DRAIN;
                    else if (WD && m_wd == PT - 1) begin m_ph = P_NEXT; m_to = 1'b1; end
                    else m_wd++;
                end
                P_DRAIN: if (out_ready) begin
                    m_out++;
                    if (m_out == OB) m_ph = P_NEXT;
                end
                P_NEXT: if (m_tile == NT - 1) m_ph = P_DONE;
                        else begin m_tile++; m_ph = P_CRST; end
                default: m_ph = P_IDLE;
            endcase
        end
        @(posedge clk);
    endtask

    // Kick a run and wait (bounded) for its run_done pulse; cyc counts cycles after the start cycle.
    task automatic do_run(input int budget, output int cyc);
        bit ok;
        clear_stats();
        force_start = 1'b1;
        cycle(1'b0);
        force_start = 1'b0;
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle(1'b0);
            cyc++;
            if (n_done != 0) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL run_timeout: run_done not seen, waited %0d cycles, required <= %0d", cyc, budget);
        end
    endtask

    task automatic run_counts(input string tag, input int load_exp, input int xfer_exp);
        chk({tag, "_load_beats"}, n_load, load_exp);
        chk({tag, "_edge_xfers"}, n_xfer, xfer_exp);
        chk({tag, "_core_rst"},   n_rst,  NT);
        chk({tag, "_run_done"},   n_done, 1);
        chk({tag, "_last_tile"},  int'(tile_idx), NT - 1);
    endtask

    initial begin
        int  cyc;
        bit  hit40;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; core_done = 1'b0; out_ready = 1'b0;
        pv = 100; pr = 100; done_mode = 1; start_pct = 0; hold_left = 0;
        force_start = 1'b0; hold_en = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        chk("reset_busy",     busy,     0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_load_end", load_end, 0);
        chk("reset_readable", readable, 0);
        chk("reset_tile_idx", int'(tile_idx), 0);
        cycle(1'b1);

        // zero-stall run: per tile 1 CRST + 80 LOAD + 6 PROC + 324 DRAIN + 1 NEXT = 412
        pv = 100; pr = 100; done_mode = 1;
        do_run(3000, cyc);
        run_counts("basic", 240, 972);
        chk("basic_run_len", cyc, 3 * 412 + 1);

        // source stalls
        pv = 50;
        do_run(8000, cyc);
        run_counts("stall", 240, 972);

        // sink backpressure at out_cnt=100
        pv = 100; pr = 100; hold_en = 1'b1;
        do_run(4000, cyc);
        run_counts("backpressure", 240, 972);
        chk("backpressure_run_len", cyc, 3 * 422 + 1);
        hold_en = 1'b0;

        // reset mid-LOAD at in_cnt=40
        clear_stats();
        force_start = 1'b1;
        cycle(1'b0);
        force_start = 1'b0;
        hit40 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_ph == P_LOAD && m_in == 40) begin hit40 = 1'b1; break; end
            cycle(1'b0);
        end
        chk("reach_in_cnt_40", int'(hit40), 1);
        cycle(1'b1);
        #1;
        chk("midreset_busy",     busy,     0);
        chk("midreset_in_ready", in_ready, 0);
        chk("midreset_core_rst", core_rst, 0);
        chk("midreset_tile_idx", int'(tile_idx), 0);
        cycle(1'b0);
        chk("midreset_no_done", n_done, 0);
        do_run(3000, cyc);
        run_counts("after_reset", 240, 972);

        // spurious start / core_done / in_valid with random handshakes
        pv = 70; pr = 70; done_mode = 0; start_pct = 20;
        for (int r = 0; r < 2; r++) begin
            do_run(8000, cyc);
            run_counts("random", 240, 972);
        end
        start_pct = 0;

`ifdef TILE_SEQ_WATCHDOG_EN
        // core_done never arrives: every tile times out
        pv = 100; pr = 100; done_mode = 2;
        do_run(3000, cyc);
        run_counts("watchdog", 240, 0);
        chk("watchdog_flag", int'(proc_timeout), 1);
        chk("watchdog_run_len", cyc, 3 * (1 + 80 + 16 + 1) + 1);
        done_mode = 1;
        do_run(3000, cyc);
        run_counts("watchdog_clear", 240, 972);
`endif

        repeat (3) cycle(1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
